data_mem_responder: RTL and testbench

Data-memory responder for the 5-stage RISC-V pipeline: the slave end of the core's load/store port (address, read enable, write enable, write data). It holds a word-organised SRAM model and serves byte, halfword and word accesses with sign or zero extension. It has a fixed, parameterised access latency and uses a ready/done handshake. It sits between the pipeline's MEM stage and the simulator's memory image.

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store slave for the pipeline MEM stage: word-organised SRAM model with
// fixed access latency, byte/half/word lanes and sign/zero-extended loads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        mem_ready,
  output logic        mem_done,
  output logic        mem_fault,
  output logic [31:0] mem_read_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uns_q, rd_q, wr_q;

  logic        accept, commit, fault;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wlane, rword, rshift, ldata;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == IDLE) && (mem_read_en || mem_write_en);
  assign commit = (state == WAIT) && (cnt == '0);
  assign widx   = addr_q[AW+1:2];

  // Fault is judged on the captured request, so it stays stable through DONE.
  always_comb begin
    fault = 1'b0;
    if (size_q == 2'b11)                                   fault = 1'b1;
    if (size_q == 2'b01 && addr_q[0])                      fault = 1'b1;
    if (size_q == 2'b10 && addr_q[1:0] != 2'b00)           fault = 1'b1;
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS))         fault = 1'b1;
    if (rd_q && wr_q)                                      fault = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == IDLE);
    mem_done  = (state == DONE);
    mem_fault = (state == DONE) && fault;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      mem_read_data <= '0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        addr_q  <= mem_addr;
        wdata_q <= mem_write_data;
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        rd_q    <= mem_read_en;
        wr_q    <= mem_write_en;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && rd_q && !fault) mem_read_data <= ldata;
    end
  end

  // Replicate the right-aligned store data across lanes; byte enables pick the target.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && wr_q && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rword  = mem[widx];
    rshift = rword >> {addr_q[1:0], 3'b000};
    ldata  = rword;
    case (size_q)
      2'b00: ldata = uns_q ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'b01: ldata = uns_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ldata = rword;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder at LATENCY=2.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        mem_ready;
  logic        mem_done;
  logic        mem_fault;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_ready(mem_ready), .mem_done(mem_done),
    .mem_fault(mem_fault), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for mem_done, report latency/fault/data.
  // With poke set, a conflicting store is presented throughout the busy window.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input logic poke, output logic flt, output logic [31:0] rdat,
                        output int lat);
    @(negedge clk);
    chk("ready_before_req", {31'b0, mem_ready}, 32'd1);
    mem_addr = a; mem_read_en = rd; mem_write_en = wr;
    mem_size = sz; mem_unsigned = u; mem_write_data = wd;
    @(posedge clk); #1;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    if (poke) begin
      mem_write_en = 1'b1; mem_addr = 32'h50; mem_size = 2'd2;
      mem_write_data = 32'h99999999;
    end
    chk("ready_low_after_accept", {31'b0, mem_ready}, 32'd0);
    lat = 0;
    flt = 1'b0;
    rdat = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_done) break;
      if (mem_fault) chk("fault_without_done", {31'b0, mem_fault}, 32'd0);
    end
    if (!mem_done) chk("done_timeout", 32'd0, 32'd1);
    flt  = mem_fault;
    rdat = mem_read_data;
    mem_write_en = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, mem_done}, 32'd0);
    chk("fault_low_after_done", {31'b0, mem_fault}, 32'd0);
  endtask

  initial begin
    logic        flt;
    logic [31:0] rdat;
    int          lat;

    rst_n = 1'b0;
    mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    mem_write_data = '0; mem_size = '0; mem_unsigned = 1'b0;

    //           rd    wr    addr          sz    uns   wdata         flt   rdata
    vecs.push_back('{1'b0, 1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 32'h21,   2'd0, 1'b0, 32'h80,       1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h21,   2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80});
    vecs.push_back('{1'b1, 1'b0, 32'h21,   2'd0, 1'b1, 32'h0,        1'b0, 32'h00000080});
    vecs.push_back('{1'b0, 1'b1, 32'h30,   2'd2, 1'b0, 32'h11223344, 1'b0, 32'h00000080});
    vecs.push_back('{1'b0, 1'b1, 32'h32,   2'd1, 1'b0, 32'h0000ABCD, 1'b0, 32'h00000080});
    vecs.push_back('{1'b1, 1'b0, 32'h30,   2'd2, 1'b0, 32'h0,        1'b0, 32'hABCD3344});
    vecs.push_back('{1'b1, 1'b0, 32'h32,   2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFFABCD});
    vecs.push_back('{1'b1, 1'b0, 32'h30,   2'd1, 1'b1, 32'h0,        1'b0, 32'h00003344});
    vecs.push_back('{1'b1, 1'b0, 32'h42,   2'd2, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b1, 1'b0, 32'h31,   2'd1, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b1, 1'b0, 32'h10,   2'd3, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b1, 1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b1, 1'b1, 32'h10,   2'd2, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b0, 1'b1, 32'h12,   2'd2, 1'b0, 32'h0,        1'b1, 32'h00003344});
    vecs.push_back('{1'b1, 1'b0, 32'h10,   2'd2, 1'b1, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 32'h33,   2'd0, 1'b0, 32'h12345677, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h30,   2'd2, 1'b0, 32'h0,        1'b0, 32'h77CD3344});
    vecs.push_back('{1'b1, 1'b0, 32'h30,   2'd0, 1'b0, 32'h0,        1'b0, 32'h00000044});
    vecs.push_back('{1'b0, 1'b1, 32'hFFC,  2'd2, 1'b0, 32'h5A5A5A5A, 1'b0, 32'h00000044});
    vecs.push_back('{1'b1, 1'b0, 32'hFFC,  2'd2, 1'b0, 32'h0,        1'b0, 32'h5A5A5A5A});

    #12;
    chk("reset_ready", {31'b0, mem_ready}, 32'd1);
    chk("reset_done",  {31'b0, mem_done},  32'd0);
    chk("reset_fault", {31'b0, mem_fault}, 32'd0);
    chk("reset_rdata", mem_read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns,
             vecs[i].wdata, 1'b0, flt, rdat, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
      chk($sformatf("vec%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].exp_fault});
      chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
    end

    // A store presented while busy must be dropped.
    do_req(1'b0, 1'b1, 32'h50, 2'd2, 1'b0, 32'h11111111, 1'b0, flt, rdat, lat);
    do_req(1'b1, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0, 1'b1, flt, rdat, lat);
    chk("busy_load_rdata", rdat, 32'h11111111);
    do_req(1'b1, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0, 1'b0, flt, rdat, lat);
    chk("busy_reload_rdata", rdat, 32'h11111111);
    chk("busy_reload_fault", {31'b0, flt}, 32'd0);

    // Reset one cycle before the commit edge: no write, no done pulse.
    do_req(1'b0, 1'b1, 32'h60, 2'd2, 1'b0, 32'h0A0B0C0D, 1'b0, flt, rdat, lat);
    @(negedge clk);
    mem_addr = 32'h60; mem_write_en = 1'b1; mem_size = 2'd0; mem_write_data = 32'h55;
    @(posedge clk); #1;
    mem_write_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, mem_ready}, 32'd1);
    chk("midrst_done",  {31'b0, mem_done},  32'd0);
    chk("midrst_rdata", mem_read_data, 32'h0);
    @(posedge clk); #1;
    chk("midrst_done_at_commit_edge", {31'b0, mem_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done_after", {31'b0, mem_done}, 32'd0);
    end
    do_req(1'b1, 1'b0, 32'h60, 2'd2, 1'b0, 32'h0, 1'b0, flt, rdat, lat);
    chk("midrst_loc_unchanged", rdat, 32'h0A0B0C0D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
